ms_cfg_slave: RTL and testbench

Responder end of the master/slave config link. Decodes framed byte traffic driven by the master (ma_send_data / ma_sel / ma_enable) and addressed to this slave's select code. Write frames update a 16-bit config register, which drives the target interface. Read frames return that register over sl_send_data. Sits between the master_if and target_if agents' DUT ports.

---
 rtl/ms_cfg_if.sv | 18 +
 rtl/ms_cfg_slave.sv | 152 +++++++++++++++
 tb/tb_ms_cfg_slave.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ms_cfg_if.sv
// Byte-framed master/slave config link: master command/data lanes and slave response lanes.
interface ms_cfg_if;
    logic [7:0] ma_send_data;
    logic [3:0] ma_sel;
    logic       ma_enable;
    logic [7:0] sl_send_data;
    logic       sl_valid;

    modport master (
        output ma_send_data, ma_sel, ma_enable,
        input  sl_send_data, sl_valid
    );

    modport slave (
        input  ma_send_data, ma_sel, ma_enable,
        output sl_send_data, sl_valid
    );
endinterface

// File: rtl/ms_cfg_slave.sv
// Responder on the config link: decodes write/read frames addressed to SLAVE_ID and
// maintains a 16-bit config register that is only ever updated as a whole.
module ms_cfg_slave #(
    parameter logic [3:0] SLAVE_ID = 4'd0,
    parameter logic [7:0] CMD_WR   = 8'hA5,
    parameter logic [7:0] CMD_RD   = 8'h5A,
    parameter logic [7:0] ACK      = 8'h06,
    parameter logic [7:0] NAK      = 8'h15
) (
    input  logic        clk,
    input  logic        rst_n,
    ms_cfg_if.slave     bus,
    output logic [15:0] config_data,
    output logic        config_valid,
    output logic [7:0]  abort_count,
    output logic        busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR_LO = 3'd1;
    localparam logic [2:0] WR_HI = 3'd2;
    localparam logic [2:0] RD_LO = 3'd3;
    localparam logic [2:0] RD_HI = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  shadow_hi_q, shadow_hi_d;
    logic [15:0] cfg_q, cfg_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic [7:0]  sl_data_q, sl_data_d;
    logic        sl_valid_q, sl_valid_d;
    logic [7:0]  abort_q, abort_d;
    logic        busy_q;
    logic        hit;
    logic        abort_evt;

    assign hit = bus.ma_enable && (bus.ma_sel == SLAVE_ID);

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        cfg_d       = cfg_q;
        cfg_valid_d = 1'b0;
        sl_data_d   = 8'h00;
        sl_valid_d  = 1'b0;
        abort_evt   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (bus.ma_send_data == CMD_WR) begin
                        state_d = WR_LO;
                    end else if (bus.ma_send_data == CMD_RD) begin
                        // Low byte goes out straight away; only the high byte needs holding.
                        state_d     = RD_LO;
                        shadow_hi_d = cfg_q[15:8];
                        sl_data_d   = cfg_q[7:0];
                        sl_valid_d  = 1'b1;
                    end else begin
                        state_d    = DRAIN;
                        sl_data_d  = NAK;
                        sl_valid_d = 1'b1;
                    end
                end
            end
            WR_LO: begin
                if (hit) begin
                    lo_d    = bus.ma_send_data;
                    state_d = WR_HI;
                end else begin
                    abort_evt = 1'b1;
                end
            end
            WR_HI: begin
                if (hit) begin
                    cfg_d       = {bus.ma_send_data, lo_q};
                    cfg_valid_d = 1'b1;
                    sl_data_d   = ACK;
                    sl_valid_d  = 1'b1;
                    state_d     = DRAIN;
                end else begin
                    abort_evt = 1'b1;
                end
            end
            RD_LO: begin
                if (hit) begin
                    sl_data_d  = shadow_hi_q;
                    sl_valid_d = 1'b1;
                    state_d    = RD_HI;
                end else begin
                    abort_evt = 1'b1;
                end
            end
            RD_HI: begin
                if (hit) begin
                    state_d = DRAIN;
                end else begin
                    abort_evt = 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.ma_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An abort lands in DRAIN when enable is still high so the tail is never decoded.
        if (abort_evt) begin
            state_d = bus.ma_enable ? DRAIN : IDLE;
        end
    end

    assign abort_d = (abort_evt && abort_q != 8'hFF) ? abort_q + 8'd1 : abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lo_q        <= 8'h00;
            shadow_hi_q <= 8'h00;
            cfg_q       <= 16'h0000;
            cfg_valid_q <= 1'b0;
            sl_data_q   <= 8'h00;
            sl_valid_q  <= 1'b0;
            abort_q     <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            sl_data_q   <= sl_data_d;
            sl_valid_q  <= sl_valid_d;
            abort_q     <= abort_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.sl_send_data = sl_data_q;
    assign bus.sl_valid     = sl_valid_q;
    assign config_data      = cfg_q;
    assign config_valid     = cfg_valid_q;
    assign abort_count      = abort_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_ms_cfg_slave.sv
// Self-checking bench for ms_cfg_slave: directed frames plus randomized traffic against a
// frame-level model (config value, abort count, expected response bytes).
module tb_ms_cfg_slave;

    localparam logic [3:0] ID  = 4'd0;
    localparam logic [7:0] WR  = 8'hA5;
    localparam logic [7:0] RD  = 8'h5A;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk;
    logic        rst_n;
    logic [15:0] config_data;
    logic        config_valid;
    logic [7:0]  abort_count;
    logic        busy;

    ms_cfg_if bus ();

    ms_cfg_slave dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .config_data  (config_data),
        .config_valid (config_valid),
        .abort_count  (abort_count),
        .busy         (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Frame-level reference state.
    logic [15:0] model_cfg;
    int          model_abort;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Apply one cycle of master stimulus, then sample just after the edge that consumed it.
    task automatic drive(input logic en, input logic [3:0] sel, input logic [7:0] d);
        bus.ma_enable    = en;
        bus.ma_sel       = sel;
        bus.ma_send_data = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_abort();
        return (model_abort > 255) ? 8'hFF : 8'(model_abort);
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        bus.ma_enable = 1'b0; bus.ma_sel = 4'h0; bus.ma_send_data = 8'h00;
        #2 rst_n = 1'b0;
        #5;
        if ({bus.sl_send_data, bus.sl_valid, config_data, config_valid, abort_count, busy} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: got sl=%h v=%b cfg=%h cv=%b ab=%h busy=%b want all 0",
                     bus.sl_send_data, bus.sl_valid, config_data, config_valid, abort_count, busy);
        end
        checks++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_cfg = 16'h0000;
        model_abort = 0;
        drive(1'b0, ID, 8'h00);
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy=%b want 0", busy); end
        checks++;
    endtask

    task automatic test_write(input logic [7:0] lo, input logic [7:0] hi);
        drive(1'b1, ID, WR);
        if (busy !== 1'b1 || bus.sl_valid !== 1'b0 || config_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_cmd: busy=%b sl_valid=%b cv=%b want 1 0 0", busy, bus.sl_valid, config_valid);
        end
        checks++;
        drive(1'b1, ID, lo);
        if (config_valid !== 1'b0 || bus.sl_valid !== 1'b0 || config_data !== model_cfg) begin
            failures++;
            $display("FAIL wr_lo_no_partial: cv=%b sl_valid=%b cfg=%h want 0 0 %h",
                     config_valid, bus.sl_valid, config_data, model_cfg);
        end
        checks++;
        drive(1'b1, ID, hi);
        model_cfg = {hi, lo};
        if (config_data !== model_cfg || config_valid !== 1'b1 || bus.sl_send_data !== ACK ||
            bus.sl_valid !== 1'b1 || abort_count !== exp_abort()) begin
            failures++;
            $display("FAIL wr_commit: cfg=%h cv=%b sl=%h v=%b ab=%h want %h 1 %h 1 %h",
                     config_data, config_valid, bus.sl_send_data, bus.sl_valid, abort_count,
                     model_cfg, ACK, exp_abort());
        end
        checks++;
        drive(1'b0, ID, 8'($urandom));
        if (config_valid !== 1'b0 || bus.sl_valid !== 1'b0 || bus.sl_send_data !== 8'h00 ||
            busy !== 1'b0 || config_data !== model_cfg) begin
            failures++;
            $display("FAIL wr_after: cv=%b v=%b sl=%h busy=%b cfg=%h want 0 0 00 0 %h",
                     config_valid, bus.sl_valid, bus.sl_send_data, busy, config_data, model_cfg);
        end
        checks++;
        drive(1'b0, ID, 8'h00);
    endtask

    task automatic test_read();
        drive(1'b1, ID, RD);
        if (bus.sl_valid !== 1'b1 || bus.sl_send_data !== model_cfg[7:0]) begin
            failures++;
            $display("FAIL rd_lo: v=%b sl=%h want 1 %h", bus.sl_valid, bus.sl_send_data, model_cfg[7:0]);
        end
        checks++;
        drive(1'b1, ID, 8'($urandom));
        if (bus.sl_valid !== 1'b1 || bus.sl_send_data !== model_cfg[15:8]) begin
            failures++;
            $display("FAIL rd_hi: v=%b sl=%h want 1 %h", bus.sl_valid, bus.sl_send_data, model_cfg[15:8]);
        end
        checks++;
        drive(1'b1, ID, 8'($urandom));
        if (bus.sl_valid !== 1'b0 || bus.sl_send_data !== 8'h00 || busy !== 1'b1 ||
            config_data !== model_cfg || abort_count !== exp_abort()) begin
            failures++;
            $display("FAIL rd_end: v=%b sl=%h busy=%b cfg=%h ab=%h want 0 00 1 %h %h",
                     bus.sl_valid, bus.sl_send_data, busy, config_data, abort_count, model_cfg, exp_abort());
        end
        checks++;
        drive(1'b0, ID, 8'h00);
        if (busy !== 1'b0) begin failures++; $display("FAIL rd_idle: busy=%b want 0", busy); end
        checks++;
        drive(1'b0, ID, 8'h00);
    endtask

    task automatic test_bad_cmd();
        drive(1'b1, ID, 8'h77);
        if (bus.sl_valid !== 1'b1 || bus.sl_send_data !== NAK) begin
            failures++;
            $display("FAIL bad_nak: v=%b sl=%h want 1 %h", bus.sl_valid, bus.sl_send_data, NAK);
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ID, WR);
            if (config_valid !== 1'b0 || bus.sl_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bad_drain[%0d]: cv=%b v=%b busy=%b want 0 0 1", i, config_valid, bus.sl_valid, busy);
            end
            checks++;
        end
        drive(1'b0, ID, 8'h00);
        if (busy !== 1'b0 || config_data !== model_cfg) begin
            failures++;
            $display("FAIL bad_idle: busy=%b cfg=%h want 0 %h", busy, config_data, model_cfg);
        end
        checks++;
        drive(1'b0, ID, 8'h00);
    endtask

    task automatic check_abort(input string name, input logic exp_busy);
        model_abort++;
        if (abort_count !== exp_abort() || config_valid !== 1'b0 || bus.sl_valid !== 1'b0 ||
            config_data !== model_cfg || busy !== exp_busy) begin
            failures++;
            $display("FAIL %s: ab=%h cv=%b v=%b cfg=%h busy=%b want %h 0 0 %h %b", name,
                     abort_count, config_valid, bus.sl_valid, config_data, busy, exp_abort(), model_cfg, exp_busy);
        end
        checks++;
    endtask

    task automatic test_abort_write();
        drive(1'b1, ID, WR);
        drive(1'b1, ID, 8'($urandom));
        drive(1'b0, ID, 8'($urandom));
        check_abort("abort_wr_after_lo", 1'b0);
        drive(1'b0, ID, 8'h00);
    endtask

    task automatic test_abort_read();
        drive(1'b1, ID, RD);
        drive(1'b0, ID, 8'h00);
        check_abort("abort_rd_lo", 1'b0);
        drive(1'b0, ID, 8'h00);
    endtask

    task automatic test_select_filter();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? WR : 8'($urandom);
            drive(i < 3, ID + 4'd1, d);
            if (bus.sl_valid !== 1'b0 || config_valid !== 1'b0 || busy !== 1'b0 ||
                config_data !== model_cfg || abort_count !== exp_abort()) begin
                failures++;
                $display("FAIL sel_other[%0d]: v=%b cv=%b busy=%b cfg=%h ab=%h want 0 0 0 %h %h", i,
                         bus.sl_valid, config_valid, busy, config_data, abort_count, model_cfg, exp_abort());
            end
            checks++;
        end
        drive(1'b1, ID, WR);
        drive(1'b1, ID, 8'($urandom));
        drive(1'b1, ID + 4'd1, 8'($urandom));
        check_abort("sel_change_hi", 1'b1);
        drive(1'b0, ID, 8'h00);
        if (busy !== 1'b0) begin failures++; $display("FAIL sel_change_idle: busy=%b want 0", busy); end
        checks++;
        drive(1'b0, ID, 8'h00);
    endtask

    task automatic test_random();
        int op;
        logic [3:0] s;
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: test_write(8'($urandom), 8'($urandom));
                1: test_read();
                2: if ($urandom_range(0, 1) == 1) test_abort_write(); else test_abort_read();
                default: begin
                    s = 4'($urandom_range(1, 15));
                    drive(1'b1, s, WR);
                    drive(1'b1, s, 8'($urandom));
                    drive(1'b1, s, 8'($urandom));
                    if (busy !== 1'b0 || bus.sl_valid !== 1'b0 || config_valid !== 1'b0 ||
                        config_data !== model_cfg) begin
                        failures++;
                        $display("FAIL rand_unaddressed sel=%h: busy=%b v=%b cv=%b cfg=%h want 0 0 0 %h",
                                 s, busy, bus.sl_valid, config_valid, config_data, model_cfg);
                    end
                    checks++;
                    drive(1'b0, ID, 8'h00);
                end
            endcase
        end
    endtask

    task automatic test_reset_midframe();
        drive(1'b1, ID, WR);
        drive(1'b1, ID, 8'h55);
        bus.ma_send_data = 8'hAA;
        #3 rst_n = 1'b0;
        #1;
        if ({bus.sl_send_data, bus.sl_valid, config_data, config_valid, abort_count, busy} !== 35'd0) begin
            failures++;
            $display("FAIL reset_mid: sl=%h v=%b cfg=%h cv=%b ab=%h busy=%b want all 0",
                     bus.sl_send_data, bus.sl_valid, config_data, config_valid, abort_count, busy);
        end
        checks++;
        bus.ma_enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_cfg = 16'h0000;
        model_abort = 0;
        drive(1'b0, ID, 8'h00);
        if (abort_count !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after: ab=%h busy=%b want 00 0", abort_count, busy);
        end
        checks++;
        test_write(8'hEF, 8'hBE);
    endtask

    task automatic test_abort_saturate();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, ID, WR);
            drive(1'b0, ID, 8'h00);
            model_abort++;
            if (i == 9 || i == 254 || i == 299) begin
                if (abort_count !== exp_abort()) begin
                    failures++;
                    $display("FAIL abort_sat[%0d]: ab=%h want %h", i, abort_count, exp_abort());
                end
                checks++;
            end
        end
        if (abort_count !== 8'hFF || config_data !== model_cfg) begin
            failures++;
            $display("FAIL abort_sat_final: ab=%h cfg=%h want ff %h", abort_count, config_data, model_cfg);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_write(8'h34, 8'h12);
        test_read();
        test_bad_cmd();
        test_abort_write();
        test_select_filter();
        test_abort_read();
        test_random();
        test_reset_midframe();
        test_abort_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
